// File: rtl/cursor_pointer.sv
// cursor_pointer: four raw buttons -> synchronized, debounced, auto-repeating (x,y) board cursor.
// Latency: press stable from cycle 0 -> loca updates at edge DEBOUNCE_CYC+3, moved pulses one cycle later.
// Backpressure: none; steps apply in the cycle they are generated, home overrides every same-cycle step.
module cursor_pointer #(
    parameter int COORD_W      = 4,
    parameter int MAX_X        = 14,
    parameter int MAX_Y        = 14,
    parameter int WRAP         = 1,
    parameter int DEBOUNCE_CYC = 16,
    parameter int REPEAT_DELAY = 1000,
    parameter int REPEAT_RATE  = 250
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 home,
    output logic [2*COORD_W-1:0] loca,
    output logic                 moved
);

    // Button lane indices into the per-button vectors.
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;

    // Debounce counter only has to reach DEBOUNCE_CYC-1.
    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TM_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_e;

    logic [3:0]          btn_raw;
    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          deb_q, deb_d;
    logic [DB_W-1:0]     db_cnt_q [4];
    logic [DB_W-1:0]     db_cnt_d [4];
    step_state_e         st_q [4];
    step_state_e         st_d [4];
    logic [TM_W-1:0]     tmr_q [4];
    logic [TM_W-1:0]     tmr_d [4];
    logic [3:0]          step;
    logic [COORD_W-1:0]  x_d, y_d;
    logic [2*COORD_W-1:0] loca_q, loca_d, loca_prev_q;
    logic                moved_q;

    assign btn_raw = {btn_down, btn_up, btn_right, btn_left};

    // One axis move: inc/dec together cancel; edges wrap or saturate.
    function automatic logic [COORD_W-1:0] axis_next(
        input logic [COORD_W-1:0] v,
        input logic               inc,
        input logic               dec,
        input logic [COORD_W-1:0] vmax
    );
        axis_next = v;
        if (inc && !dec) begin
            if (v == vmax) axis_next = (WRAP != 0) ? '0 : vmax;
            else           axis_next = v + COORD_W'(1);
        end else if (dec && !inc) begin
            if (v == '0)   axis_next = (WRAP != 0) ? vmax : '0;
            else           axis_next = v - COORD_W'(1);
        end
    endfunction

    // Debouncer: count samples that disagree with the accepted level; any agreeing sample restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Input registers: 2-flop synchronizers, accepted levels and debounce counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // Step generator next-state: first step on press, one after the delay, then one per repeat period.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_d[i]  = st_q[i];
            tmr_d[i] = tmr_q[i];
            step[i]  = 1'b0;
            case (st_q[i])
                ST_IDLE: begin
                    if (deb_q[i]) begin
                        step[i]  = 1'b1;
                        tmr_d[i] = TM_W'(REPEAT_DELAY);
                        st_d[i]  = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!deb_q[i]) begin
                        st_d[i] = ST_IDLE;
                    end else if (tmr_q[i] == TM_W'(1)) begin
                        step[i]  = 1'b1;
                        tmr_d[i] = TM_W'(REPEAT_RATE);
                        st_d[i]  = ST_REPEAT;
                    end else begin
                        tmr_d[i] = tmr_q[i] - TM_W'(1);
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase
        end
    end

    // Step generator state and repeat timers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= ST_IDLE;
                tmr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
            end
        end
    end

    // Cursor next value: independent axes, home wins over any step.
    always_comb begin
        x_d    = axis_next(loca_q[COORD_W-1:0], step[BTN_R], step[BTN_L], COORD_W'(MAX_X));
        y_d    = axis_next(loca_q[2*COORD_W-1:COORD_W], step[BTN_U], step[BTN_D], COORD_W'(MAX_Y));
        loca_d = home ? '0 : {y_d, x_d};
    end

    // Cursor register; moved compares the current and previous cursor so it lands the cycle after a change.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loca_q      <= '0;
            loca_prev_q <= '0;
            moved_q     <= 1'b0;
        end else begin
            loca_q      <= loca_d;
            loca_prev_q <= loca_q;
            moved_q     <= (loca_q != loca_prev_q);
        end
    end

    assign loca  = loca_q;
    assign moved = moved_q;

endmodule

// File: tb/tb_cursor_pointer.sv
// tb_cursor_pointer: drives a wrapping and a saturating cursor_pointer from the same buttons.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: none.
module tb_cursor_pointer;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int MX = 14;
    localparam int MY = 14;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] btn = 4'b0;      // [0]=left [1]=right [2]=up [3]=down
    logic       home = 1'b0;
    logic [7:0] loca_w, loca_s;
    logic       moved_w, moved_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cursor_pointer #(.COORD_W(4), .MAX_X(MX), .MAX_Y(MY), .WRAP(1),
                     .DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_w (
        .clk(clk), .reset_n(reset_n), .btn_left(btn[0]), .btn_right(btn[1]),
        .btn_up(btn[2]), .btn_down(btn[3]), .home(home), .loca(loca_w), .moved(moved_w));

    cursor_pointer #(.COORD_W(4), .MAX_X(MX), .MAX_Y(MY), .WRAP(0),
                     .DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_s (
        .clk(clk), .reset_n(reset_n), .btn_left(btn[0]), .btn_right(btn[1]),
        .btn_up(btn[2]), .btn_down(btn[3]), .home(home), .loca(loca_s), .moved(moved_s));

    // ---------------- reference model ----------------
    // Each button: raw level reaches the debouncer two edges late; a level is accepted
    // after D identical samples in a row. Held time h counts edges with the accepted
    // level high: steps at h=0, h=RD, and every RR after that.
    bit [1:0]   m_dly  [4];
    int         m_run  [4];
    bit         m_last [4];
    bit         m_deb  [4];
    int         m_held [4];
    int         m_xw, m_yw, m_xs, m_ys;
    logic [7:0] m_prev_w, m_prev_s;
    bit         m_mv_w, m_mv_s;
    logic [7:0] exp_w, exp_s;

    assign exp_w = {m_yw[3:0], m_xw[3:0]};
    assign exp_s = {m_ys[3:0], m_xs[3:0]};

    function automatic int mv(input int v, input int d, input int mx, input bit wrap);
        if (d > 0) return (v == mx) ? (wrap ? 0 : mx) : v + 1;
        if (d < 0) return (v == 0) ? (wrap ? mx : 0) : v - 1;
        return v;
    endfunction

    always @(posedge clk) begin
        bit [3:0]   stp;
        bit         ss;
        int         dx, dy;
        logic [7:0] cur_w, cur_s;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_dly[i] = 2'b0; m_run[i] = 0; m_last[i] = 1'b0; m_deb[i] = 1'b0; m_held[i] = 0;
            end
            m_xw = 0; m_yw = 0; m_xs = 0; m_ys = 0;
            m_prev_w = 8'h0; m_prev_s = 8'h0; m_mv_w = 1'b0; m_mv_s = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                stp[i] = 1'b0;
                if (m_deb[i]) begin
                    stp[i] = (m_held[i] == 0) || (m_held[i] == RD) ||
                             (m_held[i] > RD && (m_held[i] - RD) % RR == 0);
                    m_held[i]++;
                end else begin
                    m_held[i] = 0;
                end
                ss = m_dly[i][1];
                if (ss == m_last[i] && m_run[i] > 0) m_run[i] = (m_run[i] < D) ? m_run[i] + 1 : D;
                else m_run[i] = 1;
                m_last[i] = ss;
                if (m_run[i] >= D) m_deb[i] = ss;
                m_dly[i] = {m_dly[i][0], btn[i]};
            end
            cur_w = {m_yw[3:0], m_xw[3:0]};
            cur_s = {m_ys[3:0], m_xs[3:0]};
            m_mv_w = (cur_w != m_prev_w);
            m_mv_s = (cur_s != m_prev_s);
            m_prev_w = cur_w;
            m_prev_s = cur_s;
            dx = int'(stp[1]) - int'(stp[0]);
            dy = int'(stp[2]) - int'(stp[3]);
            if (home) begin
                m_xw = 0; m_yw = 0; m_xs = 0; m_ys = 0;
            end else begin
                m_xw = mv(m_xw, dx, MX, 1'b1); m_yw = mv(m_yw, dy, MY, 1'b1);
                m_xs = mv(m_xs, dx, MX, 1'b0); m_ys = mv(m_ys, dy, MY, 1'b0);
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int idx, input int hi, input int lo);
        btn[idx] = 1'b1; run(hi);
        btn[idx] = 1'b0; run(lo);
    endtask

    task automatic go_home();
        home = 1'b1; tick(); home = 1'b0; run(3);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; btn = 4'b0100; home = 1'b0;
        run(2);
        checks++;
        if ({loca_w, moved_w, loca_s, moved_s} !== 18'h0)
            begin errors++; $display("FAIL reset_state: got w=%h/%b s=%h/%b want 00/0", loca_w, moved_w, loca_s, moved_s); end
        reset_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (loca_w !== ((c >= 7) ? 8'h10 : 8'h00) || moved_w !== (c == 8) ||
                loca_s !== ((c >= 7) ? 8'h10 : 8'h00) || moved_s !== (c == 8))
                begin errors++; $display("FAIL reset_latency c=%0d: got w=%h/%b s=%h/%b", c, loca_w, moved_w, loca_s, moved_s); end
        end
        btn = 4'b0;
        run(12);
    endtask

    task automatic test_glitch();
        for (int c = 1; c <= 16; c++) begin
            btn[1] = (c <= 3);
            tick();
            checks++;
            if (loca_w !== 8'h10 || moved_w !== 1'b0 || loca_s !== 8'h10 || moved_s !== 1'b0)
                begin errors++; $display("FAIL glitch c=%0d: got w=%h/%b s=%h/%b want 10/0", c, loca_w, moved_w, loca_s, moved_s); end
        end
    endtask

    task automatic test_wrap_saturate();
        go_home();
        for (int c = 1; c <= 16; c++) begin
            btn[0] = (c <= 8);
            tick();
            checks++;
            if (loca_w !== ((c >= 7) ? 8'h0E : 8'h00) || loca_s !== 8'h00 || moved_s !== 1'b0)
                begin errors++; $display("FAIL wrap_left c=%0d: got w=%h s=%h/%b", c, loca_w, loca_s, moved_s); end
        end
        for (int c = 1; c <= 16; c++) begin
            btn[1] = (c <= 8);
            tick();
            checks++;
            if (loca_w !== ((c >= 7) ? 8'h00 : 8'h0E) || loca_s !== ((c >= 7) ? 8'h01 : 8'h00))
                begin errors++; $display("FAIL wrap_right c=%0d: got w=%h s=%h", c, loca_w, loca_s); end
        end
        for (int c = 1; c <= 110; c++) begin
            btn[1] = (c <= 90);
            tick();
            checks++;
            if ({loca_w, moved_w, loca_s, moved_s} !== {exp_w, m_mv_w, exp_s, m_mv_s})
                begin errors++; $display("FAIL model_hold_right c=%0d: got w=%h/%b s=%h/%b want w=%h/%b s=%h/%b",
                    c, loca_w, moved_w, loca_s, moved_s, exp_w, m_mv_w, exp_s, m_mv_s); end
        end
        checks++;
        if (loca_s !== 8'h0E)
            begin errors++; $display("FAIL sat_reach: got s=%h want 0e", loca_s); end
        for (int c = 1; c <= 16; c++) begin
            btn[1] = (c <= 8);
            tick();
            checks++;
            if (loca_s !== 8'h0E || moved_s !== 1'b0)
                begin errors++; $display("FAIL sat_right c=%0d: got s=%h/%b want 0e/0", c, loca_s, moved_s); end
        end
    endtask

    task automatic test_repeat();
        int ts [8];
        int yw [8];
        ts = '{7, 27, 32, 37, 42, 47, 52, 57};
        yw = '{4, 3, 2, 1, 0, 14, 13, 12};
        go_home();
        repeat (5) press(2, 8, 10);
        checks++;
        if (loca_w !== 8'h50 || loca_s !== 8'h50)
            begin errors++; $display("FAIL repeat_start: got w=%h s=%h want 50", loca_w, loca_s); end
        // Raw down held for 55 edges; the accepted level stays high until edge 61,
        // so the edge-57 step lands and the edge-62 one does not.
        for (int c = 1; c <= 90; c++) begin
            btn[3] = (c <= 55);
            tick();
            checks++;
            if ({loca_w, moved_w, loca_s, moved_s} !== {exp_w, m_mv_w, exp_s, m_mv_s})
                begin errors++; $display("FAIL model_repeat c=%0d: got w=%h/%b s=%h/%b want w=%h/%b s=%h/%b",
                    c, loca_w, moved_w, loca_s, moved_s, exp_w, m_mv_w, exp_s, m_mv_s); end
            for (int k = 0; k < 8; k++) begin
                if (c == ts[k]) begin
                    checks++;
                    if (loca_w[7:4] !== 4'(yw[k]) || loca_s[7:4] !== ((k <= 4) ? 4'(yw[k]) : 4'd0))
                        begin errors++; $display("FAIL repeat_step t=%0d: got yw=%0d ys=%0d want yw=%0d", c, loca_w[7:4], loca_s[7:4], yw[k]); end
                end
            end
            if (c > 58) begin
                checks++;
                if (loca_w !== 8'hC0 || loca_s !== 8'h00)
                    begin errors++; $display("FAIL repeat_release c=%0d: got w=%h s=%h want c0/00", c, loca_w, loca_s); end
            end
        end
    endtask

    task automatic test_opposing();
        go_home();
        for (int c = 1; c <= 14; c++) begin
            btn = (c <= 10) ? 4'b0111 : 4'b0000;
            tick();
            checks++;
            if (loca_w !== ((c >= 7) ? 8'h10 : 8'h00) || moved_w !== (c == 8) ||
                loca_s !== ((c >= 7) ? 8'h10 : 8'h00) || moved_s !== (c == 8))
                begin errors++; $display("FAIL opposing c=%0d: got w=%h/%b s=%h/%b", c, loca_w, moved_w, loca_s, moved_s); end
        end
        run(8);
    endtask

    task automatic test_home();
        go_home();
        repeat (3) press(1, 8, 10);
        repeat (7) press(2, 8, 10);
        checks++;
        if (loca_w !== 8'h73 || loca_s !== 8'h73)
            begin errors++; $display("FAIL home_setup: got w=%h s=%h want 73", loca_w, loca_s); end
        for (int c = 1; c <= 8; c++) begin
            btn[1] = 1'b1;
            home = (c == 7);
            tick();
        end
        home = 1'b0;
        checks++;
        if (loca_w !== 8'h00 || loca_s !== 8'h00 || moved_w !== 1'b1 || moved_s !== 1'b1)
            begin errors++; $display("FAIL home_step: got w=%h/%b s=%h/%b want 00/1", loca_w, moved_w, loca_s, moved_s); end
        btn[1] = 1'b0;
        run(12);
        home = 1'b1; tick(); home = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (loca_w !== 8'h00 || moved_w !== 1'b0 || loca_s !== 8'h00 || moved_s !== 1'b0)
                begin errors++; $display("FAIL home_at_origin c=%0d: got w=%h/%b s=%h/%b want 00/0", c, loca_w, moved_w, loca_s, moved_s); end
        end
    endtask

    task automatic test_midhold_reset();
        btn = 4'b0001;
        run(10);
        reset_n = 1'b0; run(2); reset_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (loca_w !== ((c >= 7) ? 8'h0E : 8'h00) || moved_w !== (c == 8) ||
                loca_s !== 8'h00 || moved_s !== 1'b0)
                begin errors++; $display("FAIL midhold_reset c=%0d: got w=%h/%b s=%h/%b", c, loca_w, moved_w, loca_s, moved_s); end
        end
        btn = 4'b0;
        run(10);
    endtask

    task automatic test_random();
        for (int c = 1; c <= 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
            home = ($urandom_range(0, 79) == 0);
            tick();
            checks++;
            if ({loca_w, moved_w, loca_s, moved_s} !== {exp_w, m_mv_w, exp_s, m_mv_s})
                begin errors++; $display("FAIL model_random c=%0d: got w=%h/%b s=%h/%b want w=%h/%b s=%h/%b",
                    c, loca_w, moved_w, loca_s, moved_s, exp_w, m_mv_w, exp_s, m_mv_s); end
        end
        btn = 4'b0; home = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_wrap_saturate();
        test_repeat();
        test_opposing();
        test_home();
        test_midhold_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
